// File: rtl/dual_grant_arb_pkg.sv
// Shared types and helpers for the dual-grant round-robin arbiter.
// Optional requester masking is enabled by defining DUAL_GRANT_ARB_MASK_EN.
package dual_grant_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    // Advance a requester index by one, wrapping from n-1 back to 0.
    function automatic int unsigned ptr_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rot_two_hot_pick.sv
// Combinational picker: the first and second set requests in rotating priority order from i_ptr.
// The vector is rotated so that i_ptr lands at bit 0, searched from the bottom, then rotated back.
module rot_two_hot_pick
    import dual_grant_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 12,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_first,
    output logic [NUM_REQ-1:0] o_second,
    output logic [1:0]         o_cnt
);

    logic [NUM_REQ-1:0] w_rot;
    logic [NUM_REQ-1:0] w_pre1;
    logic [NUM_REQ-1:0] w_first_r;
    logic [NUM_REQ-1:0] w_rot2;
    logic [NUM_REQ-1:0] w_pre2;
    logic [NUM_REQ-1:0] w_second_r;

    // Rotate right by i_ptr: rotated bit i holds requester (i + ptr) mod NUM_REQ.
    always_comb begin
        int unsigned k;
        w_rot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = i + 32'(i_ptr);
            if (k >= NUM_REQ) k = k - NUM_REQ;
            w_rot[i] = i_req[k];
        end
    end

    // Prefix-OR marks every bit above the lowest set bit; clearing that bit exposes the second pick.
    always_comb begin
        w_pre1 = '0;
        w_pre2 = '0;
        for (int unsigned i = 1; i < NUM_REQ; i++) begin
            w_pre1[i] = w_pre1[i-1] | w_rot[i-1];
        end
        w_first_r = w_rot & ~w_pre1;
        w_rot2    = w_rot & ~w_first_r;
        for (int unsigned i = 1; i < NUM_REQ; i++) begin
            w_pre2[i] = w_pre2[i-1] | w_rot2[i-1];
        end
        w_second_r = w_rot2 & ~w_pre2;
    end

    // Rotate back left by i_ptr.
    always_comb begin
        int unsigned k;
        o_first  = '0;
        o_second = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            k = j + NUM_REQ - 32'(i_ptr);
            if (k >= NUM_REQ) k = k - NUM_REQ;
            o_first[j]  = w_first_r[k];
            o_second[j] = w_second_r[k];
        end
    end

    always_comb begin
        if (|w_second_r)     o_cnt = 2'd2;
        else if (|w_first_r) o_cnt = 2'd1;
        else                 o_cnt = 2'd0;
    end

endmodule

// File: rtl/dual_grant_rr_arbiter.sv
// Round-robin arbiter issuing up to two one-hot grants per valid/ready transaction.
// Define DUAL_GRANT_ARB_MASK_EN to add the mask_i port that blocks selected requesters.
module dual_grant_rr_arbiter
    import dual_grant_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 12,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
`ifdef DUAL_GRANT_ARB_MASK_EN
    input  logic [NUM_REQ-1:0] mask_i,
`endif
    output logic               gnt_valid_o,
    input  logic               gnt_ready_i,
    output logic [NUM_REQ-1:0] gnt0_o,
    output logic [NUM_REQ-1:0] gnt1_o,
    output logic [1:0]         gnt_cnt_o
);

    arb_state_t         r_state, w_state_nx;
    logic [PTR_W-1:0]   r_ptr, w_ptr_nx;
    logic [NUM_REQ-1:0] r_gnt0, w_gnt0_nx;
    logic [NUM_REQ-1:0] r_gnt1, w_gnt1_nx;
    logic [1:0]         r_cnt, w_cnt_nx;

    logic [NUM_REQ-1:0] w_req_eff;
    logic               w_hs;
    logic [NUM_REQ-1:0] w_last_vec;
    logic [PTR_W-1:0]   w_last_idx;
    logic [PTR_W-1:0]   w_ptr_hs;
    logic [PTR_W-1:0]   w_pick_ptr;
    logic [NUM_REQ-1:0] w_pick0, w_pick1;
    logic [1:0]         w_pick_cnt;

`ifdef DUAL_GRANT_ARB_MASK_EN
    assign w_req_eff = req_i & ~mask_i;
`else
    assign w_req_eff = req_i;
`endif

    assign w_hs = (r_state == HOLD) && gnt_ready_i;

    // The pointer moves past the last grant actually issued in the held pair.
    always_comb begin
        w_last_vec = (r_cnt == 2'd2) ? r_gnt1 : r_gnt0;
        w_last_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_last_vec[i]) w_last_idx = PTR_W'(i);
        end
    end

    assign w_ptr_hs   = PTR_W'(ptr_inc(32'(w_last_idx), NUM_REQ));
    // A handshake cycle re-picks with the advanced pointer so back-to-back pairs have no bubble.
    assign w_pick_ptr = w_hs ? w_ptr_hs : r_ptr;

    rot_two_hot_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .i_req    (w_req_eff),
        .i_ptr    (w_pick_ptr),
        .o_first  (w_pick0),
        .o_second (w_pick1),
        .o_cnt    (w_pick_cnt)
    );

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_gnt0_nx  = r_gnt0;
        w_gnt1_nx  = r_gnt1;
        w_cnt_nx   = r_cnt;
        case (r_state)
            IDLE: begin
                if (|w_req_eff) begin
                    w_state_nx = HOLD;
                    w_gnt0_nx  = w_pick0;
                    w_gnt1_nx  = w_pick1;
                    w_cnt_nx   = w_pick_cnt;
                end
            end
            HOLD: begin
                if (w_hs) begin
                    w_ptr_nx = w_ptr_hs;
                    if (|w_req_eff) begin
                        w_gnt0_nx = w_pick0;
                        w_gnt1_nx = w_pick1;
                        w_cnt_nx  = w_pick_cnt;
                    end else begin
                        w_state_nx = IDLE;
                        w_gnt0_nx  = '0;
                        w_gnt1_nx  = '0;
                        w_cnt_nx   = '0;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt0  <= '0;
            r_gnt1  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_gnt0  <= w_gnt0_nx;
            r_gnt1  <= w_gnt1_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    assign gnt_valid_o = (r_state == HOLD);
    assign gnt0_o      = r_gnt0;
    assign gnt1_o      = r_gnt1;
    assign gnt_cnt_o   = r_cnt;

endmodule

// File: tb/tb_dual_grant_rr_arbiter.sv
// Scoreboard bench for dual_grant_rr_arbiter (NUM_REQ=12); covers mask_i when DUAL_GRANT_ARB_MASK_EN is defined.
module tb_dual_grant_rr_arbiter;

    localparam int unsigned N = 12;
    localparam int unsigned W = 2 * N + 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req_i;
    logic         gnt_ready_i;
    logic         gnt_valid_o;
    logic [N-1:0] gnt0_o, gnt1_o;
    logic [1:0]   gnt_cnt_o;
`ifdef DUAL_GRANT_ARB_MASK_EN
    logic [N-1:0] mask_i;
`endif

    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;
    logic        mon_en = 1'b0;
    logic [W-1:0] q[$];

    always #5 clk = ~clk;

    dual_grant_rr_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
`ifdef DUAL_GRANT_ARB_MASK_EN
        .mask_i      (mask_i),
`endif
        .gnt_valid_o (gnt_valid_o),
        .gnt_ready_i (gnt_ready_i),
        .gnt0_o      (gnt0_o),
        .gnt1_o      (gnt1_o),
        .gnt_cnt_o   (gnt_cnt_o)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got gnt0=%h gnt1=%h cnt=%0d, expected gnt0=%h gnt1=%h cnt=%0d",
                     name, act[W-1:N+2], act[N+1:2], act[1:0], exp[W-1:N+2], exp[N+1:2], exp[1:0]);
        end
    endtask

    function automatic logic [W-1:0] pk(input logic [N-1:0] g0, input logic [N-1:0] g1, input logic [1:0] c);
        return {g0, g1, c};
    endfunction

    // Monitor: any valid pair must match the scoreboard head; it is retired on handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            if (gnt_valid_o) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got gnt0=%h gnt1=%h, expected no valid", gnt0_o, gnt1_o);
                end else begin
                    chk("grant", {gnt0_o, gnt1_o, gnt_cnt_o}, q[0]);
                    if (gnt_ready_i) void'(q.pop_front());
                end
            end else begin
                chk("idle_zero", {gnt0_o, gnt1_o, gnt_cnt_o}, '0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_valid(input string name, input logic exp);
        @(negedge clk);
        n_vec++;
        if (gnt_valid_o !== exp) begin
            n_fail++;
            $display("FAIL %s: got valid=%b, expected valid=%b", name, gnt_valid_o, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        req_i       = '0;
        gnt_ready_i = 1'b0;
`ifdef DUAL_GRANT_ARB_MASK_EN
        mask_i      = '0;
`endif
        // Reset for two cycles, then idle with no requests.
        cyc();
        mon_en = 1'b1;
        cyc();
        reset = 1'b0;
        repeat (5) cyc();

        // ptr=0, 0x026 -> {002,004}; ptr=3 re-pick -> {020,002}; ptr=2, 0x800 -> {800}, then ptr wraps to 0.
        req_i       = 12'h026;
        gnt_ready_i = 1'b1;
        q.push_back(pk(12'h002, 12'h004, 2'd2));
        q.push_back(pk(12'h020, 12'h002, 2'd2));
        cyc();
        cyc();
        req_i = 12'h800;
        q.push_back(pk(12'h800, 12'h000, 2'd1));
        cyc();
        req_i = '0;
        cyc();
        cyc();

        // Backpressure at ptr=0: 0x081 -> {001,080}; then handshake with 0x300 from ptr=8 -> {100,200}.
        gnt_ready_i = 1'b0;
        req_i       = 12'h081;
        q.push_back(pk(12'h001, 12'h080, 2'd2));
        cyc();
        repeat (6) begin
            req_i = N'($urandom);
            cyc();
        end
        req_i       = 12'h300;
        gnt_ready_i = 1'b1;
        q.push_back(pk(12'h100, 12'h200, 2'd2));
        cyc();
        gnt_ready_i = 1'b0;
        req_i       = '0;
        chk_valid("no_bubble", 1'b1);

        // Reset while holding a pair: outputs clear and ptr returns to 0.
        #1;
        q.delete();
        reset = 1'b1;
        cyc();
        chk_valid("reset_in_hold", 1'b0);
        #1;
        reset       = 1'b0;
        req_i       = 12'h801;
        gnt_ready_i = 1'b1;
        q.push_back(pk(12'h001, 12'h800, 2'd2));
        cyc();
        req_i = '0;
        cyc();
        cyc();

`ifdef DUAL_GRANT_ARB_MASK_EN
        mask_i = 12'h002;
        req_i  = 12'h006;
        q.push_back(pk(12'h004, 12'h000, 2'd1));
        cyc();
        req_i  = '0;
        mask_i = '0;
        cyc();
        cyc();
`endif

        // Bounded drain of anything still expected.
        for (int i = 0; i < 20 && q.size() != 0; i++) cyc();
        if (q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: got %0d pending pairs, expected 0", q.size());
        end
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
